ahbl_gpio_multi: RTL and testbench
==================================

Name: ahbl_gpio_multi

Overview:
Parametrised AHB-Lite GPIO peripheral; successor to the fixed three-port 32-bit GPIO on the Hazard2 SoC bus. Provides NUM_PORTS independent ports of WIDTH bits each, with per-port output/OE registers, atomic set/clear, metastability-synchronised inputs, and per-pin edge-triggered interrupts. Sits on the AHB-Lite splitter as a zero-wait-state slave; pins go to the SoC top.

Parameters:
NUM_PORTS, 3, number of GPIO ports (1..8)
WIDTH, 32, bits per port (1..32); unused register bits read 0 and ignore writes
SYNC_STAGES, 2, input synchroniser depth (2..3)

Ports:
HCLK  in  1  bus/system clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  32  address; bits [7:5] port index, [4:2] register, others ignored
HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ
HWRITE  in  1  write strobe
HSIZE  in  3  ignored; all accesses treated as 32-bit
HREADY  in  1  bus ready
HWDATA  in  32  write data (data phase)
HREADYOUT  out  1  always 1
HRESP  out  1  always 0 (OKAY)
HRDATA  out  32  read data (data phase)
GPIO_OUT  out  NUM_PORTS*WIDTH  output values; port p at [p*WIDTH +: WIDTH]
GPIO_OE  out  NUM_PORTS*WIDTH  output enables, 1 = drive
GPIO_IN  in  NUM_PORTS*WIDTH  raw asynchronous pin inputs
IRQ  out  NUM_PORTS  per-port interrupt, OR of (STATUS & IRQ_EN)

Behaviour:
- Reset (async assert, sync release on HCLK): OUT=0, OE=0, IRQ_EN=0, EDGE=0, STATUS=0, synchroniser and previous-sample flops=0, IRQ=0, address-phase regs cleared. HRDATA=0.
- Address phase: when HSEL&HREADY&HTRANS[1], latch port index, register index, HWRITE into phase regs with valid=1; otherwise valid=0.
- Data phase: write applied on the next rising edge using HWDATA; effect visible on pins 1 cycle after the data phase. Reads are combinational from the latched address; zero wait states.
- Register map per port (offset within port block): 0x00 OUT RW; 0x04 OE RW; 0x08 IN RO (synchronised value); 0x0C SET WO (OUT|=wdata, reads 0); 0x10 CLR WO (OUT&=~wdata, reads 0); 0x14 IRQ_EN RW; 0x18 EDGE RW (per bit: 0=rising, 1=falling); 0x1C STATUS R/W1C.
- Port index >= NUM_PORTS: reads 0, writes ignored, HRESP still OKAY.
- Input path: GPIO_IN passes SYNC_STAGES flops -> sync; prev <= sync every cycle. Latency pin-to-IN register = SYNC_STAGES cycles.
- Edge detect: rise = sync&~prev, fall = ~sync&prev; hit = EDGE ? fall : rise. STATUS |= hit each cycle regardless of IRQ_EN.
- W1C collision: if a STATUS W1C write and a new hit on the same bit land in the same cycle, the bit remains 1 (hit wins).
- IRQ[p] registered: IRQ asserts 1 cycle after STATUS bit set with enable; deasserts 1 cycle after clear or enable drop.
- Changing EDGE does not itself set STATUS (prev/sync are unaffected).
- Reset mid-transfer: pending data-phase write discarded; all state returns to reset values immediately.
- Back-to-back transfers: write followed by read of the same register returns the new value (write committed on edge ending its data phase, read occurs in following data phase).

Decomposition:
- Package ahbl_gpio_pkg: register offset constants (OUT, OE, IN, SET, CLR, IRQ_EN, EDGE, STATUS), port stride 0x20, HTRANS encodings.
- Sub-module gpio_port_core: one port's registers, synchroniser, edge detect, STATUS, and IRQ; instantiated NUM_PORTS times via generate. Top handles AHB decode and HRDATA mux.

Test Plan:
- Reset: hold HRESETn=0, then release -> GPIO_OUT=0, GPIO_OE=0, IRQ=0, read OUT of port 0 = 0x0.
- Write port1 OUT=0x0000_00A5, OE=0xFF, then SET 0x100, CLR 0x05 -> GPIO_OUT port1 = 0x1A0, OE=0xFF, read OUT=0x1A0; ports 0/2 unchanged.
- Drive GPIO_IN port2 = 0x3C; read IN after 2 cycles -> 0x3C; read after only 1 cycle -> old value (0x0).
- Port0 IRQ_EN=0x1, EDGE=0; toggle pin0 0->1 -> STATUS=0x1, IRQ[0]=1; write STATUS 0x1 -> IRQ[0]=0; falling edge with EDGE=0 -> no set.
- Collision: W1C STATUS bit3 in the same cycle as a detected edge on bit3 -> STATUS bit3 stays 1.
- NUM_PORTS=2, WIDTH=8 build: write 0xFFFF_FFFF to port0 OUT -> reads 0xFF; access port index 3 -> reads 0, no pin change.

Source files
------------

// File: rtl/ahbl_gpio_pkg.sv
// Shared constants and types for the multi-port AHB-Lite GPIO peripheral.
package ahbl_gpio_pkg;

  localparam int unsigned HADDR_W     = 32;
  localparam int unsigned HDATA_W     = 32;
  localparam int unsigned PORT_IDX_W  = 3;
  localparam int unsigned PORT_STRIDE = 32'h20;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // Register offsets within one port block.
  typedef enum logic [4:0] {
    OFF_OUT    = 5'h00,
    OFF_OE     = 5'h04,
    OFF_IN     = 5'h08,
    OFF_SET    = 5'h0C,
    OFF_CLR    = 5'h10,
    OFF_IRQ_EN = 5'h14,
    OFF_EDGE   = 5'h18,
    OFF_STATUS = 5'h1C
  } reg_off_e;

  typedef struct packed {
    logic                  valid;
    logic                  write;
    logic [PORT_IDX_W-1:0] port;
    reg_off_e              regsel;
  } aphase_t;

endpackage

// File: rtl/gpio_port_core.sv
// One GPIO port: OUT/OE/IRQ_EN/EDGE registers, input synchroniser,
// edge detection into a W1C STATUS register, and a registered interrupt.
module gpio_port_core
  import ahbl_gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  reg_off_e         reg_sel,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_c,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] irq_en_q;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] sync_c;
  logic [WIDTH-1:0] hit_c;
  logic [WIDTH-1:0] w1c_c;
  logic [WIDTH-1:0] status_nxt_c;

  assign sync_c = sync_q[SYNC_STAGES-1];
  assign hit_c  = (edge_q & ~sync_c & prev_q) | (~edge_q & sync_c & ~prev_q);
  assign w1c_c  = (wr_en && (reg_sel == OFF_STATUS)) ? wdata : '0;
  // A fresh edge in the same cycle as a W1C keeps the bit set.
  assign status_nxt_c = (status_q & ~w1c_c) | hit_c;

  // Input synchroniser chain and previous-sample register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_c;
    end
  end

  // Software-visible registers and interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out <= '0;
      gpio_oe  <= '0;
      irq_en_q <= '0;
      edge_q   <= '0;
      status_q <= '0;
      irq      <= 1'b0;
    end else begin
      status_q <= status_nxt_c;
      irq      <= |(status_q & irq_en_q);
      if (wr_en) begin
        case (reg_sel)
          OFF_OUT:    gpio_out <= wdata;
          OFF_OE:     gpio_oe  <= wdata;
          OFF_SET:    gpio_out <= gpio_out | wdata;
          OFF_CLR:    gpio_out <= gpio_out & ~wdata;
          OFF_IRQ_EN: irq_en_q <= wdata;
          OFF_EDGE:   edge_q   <= wdata;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    case (reg_sel)
      OFF_OUT:    rdata_c = gpio_out;
      OFF_OE:     rdata_c = gpio_oe;
      OFF_IN:     rdata_c = sync_c;
      OFF_IRQ_EN: rdata_c = irq_en_q;
      OFF_EDGE:   rdata_c = edge_q;
      OFF_STATUS: rdata_c = status_q;
      default:    rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/ahbl_gpio_multi.sv
// Zero-wait-state AHB-Lite slave exposing NUM_PORTS GPIO ports of WIDTH bits,
// one 0x20-byte register block per port.
module ahbl_gpio_multi
  import ahbl_gpio_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 3,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       HSEL,
  input  logic [HADDR_W-1:0]         HADDR,
  input  logic [1:0]                 HTRANS,
  input  logic                       HWRITE,
  input  logic [2:0]                 HSIZE,
  input  logic                       HREADY,
  input  logic [HDATA_W-1:0]         HWDATA,
  output logic                       HREADYOUT,
  output logic                       HRESP,
  output logic [HDATA_W-1:0]         HRDATA,
  output logic [NUM_PORTS*WIDTH-1:0] GPIO_OUT,
  output logic [NUM_PORTS*WIDTH-1:0] GPIO_OE,
  input  logic [NUM_PORTS*WIDTH-1:0] GPIO_IN,
  output logic [NUM_PORTS-1:0]       IRQ
);

  aphase_t          aphase_q;
  logic             xfer_c;
  logic [WIDTH-1:0] port_rdata [NUM_PORTS];
  logic             unused_bits;

  assign HREADYOUT   = 1'b1;
  assign HRESP       = 1'b0;
  assign unused_bits = ^{HADDR[31:8], HSIZE, HWDATA};
  assign xfer_c      = HSEL && HREADY &&
                       ((htrans_e'(HTRANS) == HTRANS_NONSEQ) || (htrans_e'(HTRANS) == HTRANS_SEQ));

  // Address-phase capture; valid marks a live data phase in the next cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      aphase_q <= '0;
    end else begin
      aphase_q.valid <= xfer_c;
      if (xfer_c) begin
        aphase_q.write  <= HWRITE;
        aphase_q.port   <= PORT_IDX_W'(HADDR[7:0] / 8'(PORT_STRIDE));
        aphase_q.regsel <= reg_off_e'({HADDR[4:2], 2'b00});
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic wr_en;
    assign wr_en = aphase_q.valid && aphase_q.write && (aphase_q.port == PORT_IDX_W'(p));

    gpio_port_core #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_core (
      .clk      (HCLK),
      .rst_n    (HRESETn),
      .wr_en    (wr_en),
      .reg_sel  (aphase_q.regsel),
      .wdata    (HWDATA[WIDTH-1:0]),
      .rdata_c  (port_rdata[p]),
      .gpio_out (GPIO_OUT[p*WIDTH +: WIDTH]),
      .gpio_oe  (GPIO_OE[p*WIDTH +: WIDTH]),
      .gpio_in  (GPIO_IN[p*WIDTH +: WIDTH]),
      .irq      (IRQ[p])
    );
  end

  // Read data mux; unimplemented port indices fall through to zero.
  always_comb begin
    HRDATA = '0;
    if (aphase_q.valid && !aphase_q.write) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (aphase_q.port == PORT_IDX_W'(p)) HRDATA = HDATA_W'(port_rdata[p]);
      end
    end
  end

endmodule

// File: tb/tb_ahbl_gpio_multi.sv
// Scoreboard bench for ahbl_gpio_multi: default 3x32 build plus a 2x8 build.
module tb_ahbl_gpio_multi;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic         HSEL_A, HSEL_B;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic         HWRITE;
  logic [2:0]   HSIZE;
  logic         HREADY;
  logic [31:0]  HWDATA;

  logic         HREADYOUT_A, HRESP_A, HREADYOUT_B, HRESP_B;
  logic [31:0]  HRDATA_A, HRDATA_B;
  logic [95:0]  GPIO_OUT_A, GPIO_OE_A, gin_a;
  logic [15:0]  GPIO_OUT_B, GPIO_OE_B, gin_b;
  logic [2:0]   IRQ_A;
  logic [1:0]   IRQ_B;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  always #5 HCLK = ~HCLK;

  ahbl_gpio_multi #(.NUM_PORTS(3), .WIDTH(32), .SYNC_STAGES(2)) u_dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL_A), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT_A), .HRESP(HRESP_A), .HRDATA(HRDATA_A),
    .GPIO_OUT(GPIO_OUT_A), .GPIO_OE(GPIO_OE_A), .GPIO_IN(gin_a), .IRQ(IRQ_A)
  );

  ahbl_gpio_multi #(.NUM_PORTS(2), .WIDTH(8), .SYNC_STAGES(2)) u_dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL_B), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT_B), .HRESP(HRESP_B), .HRDATA(HRDATA_B),
    .GPIO_OUT(GPIO_OUT_B), .GPIO_OE(GPIO_OE_B), .GPIO_IN(gin_b), .IRQ(IRQ_B)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_phase(input bit to_b, input logic [31:0] a, input bit wr);
    HSEL_A = !to_b;
    HSEL_B = to_b;
    HADDR  = a;
    HTRANS = 2'b10;
    HWRITE = wr;
  endtask

  task automatic bus_idle();
    HSEL_A = 1'b0;
    HSEL_B = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic ahb_write(input bit to_b, input logic [31:0] a, input logic [31:0] d);
    tick();
    addr_phase(to_b, a, 1'b1);
    tick();
    bus_idle();
    HWDATA = d;
  endtask

  task automatic ahb_read(input bit to_b, input logic [31:0] a, input logic [31:0] e, input string nm);
    tick();
    addr_phase(to_b, a, 1'b0);
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick();
    bus_idle();
  endtask

  // Write then read the same register in back-to-back pipelined transfers.
  task automatic ahb_wr_rd(input logic [31:0] a, input logic [31:0] d, input string nm);
    tick();
    addr_phase(1'b0, a, 1'b1);
    tick();
    addr_phase(1'b0, a, 1'b0);
    HWDATA = d;
    exp_q.push_back(d);
    name_q.push_back(nm);
    tick();
    bus_idle();
  endtask

  // Monitor: a read address phase seen at a rising edge yields data on the following low phase.
  bit          rd_pend;
  bit          rd_b;
  logic [31:0] mon_exp;
  string       mon_name;
  initial begin
    forever begin
      @(posedge HCLK);
      rd_pend = HRESETn && HREADY && HTRANS[1] && !HWRITE && (HSEL_A || HSEL_B);
      rd_b    = HSEL_B;
      @(negedge HCLK);
      if (rd_pend) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_read: got 0x%0h with no expected value queued", rd_b ? HRDATA_B : HRDATA_A);
        end else begin
          mon_exp  = exp_q.pop_front();
          mon_name = name_q.pop_front();
          check(mon_name, rd_b ? HRDATA_B : HRDATA_A, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d reads outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0;
    bus_idle();
    HADDR  = '0;
    HSIZE  = 3'b010;
    HREADY = 1'b1;
    HWDATA = '0;
    gin_a  = '0;
    gin_b  = '0;
    repeat (3) tick();

    // Reset values
    check("rst_gpio_out", GPIO_OUT_A, 96'h0);
    check("rst_gpio_oe", GPIO_OE_A, 96'h0);
    check("rst_irq", IRQ_A, 3'h0);
    check("rst_hrdata", HRDATA_A, 32'h0);
    check("hreadyout", HREADYOUT_A, 1'b1);
    check("hresp", HRESP_A, 1'b0);
    HRESETn = 1'b1;
    ahb_read(1'b0, 32'h00, 32'h0, "rd_p0_out_rst");

    // Port 1 OUT/OE and set/clear
    ahb_write(1'b0, 32'h20, 32'hA5);
    ahb_write(1'b0, 32'h24, 32'hFF);
    ahb_write(1'b0, 32'h2C, 32'h100);
    ahb_write(1'b0, 32'h30, 32'h05);
    tick();
    check("p1_pin_out", GPIO_OUT_A[63:32], 32'h1A0);
    check("p1_pin_oe", GPIO_OE_A[63:32], 32'hFF);
    check("p0_pin_out", GPIO_OUT_A[31:0], 32'h0);
    check("p2_pin_out", GPIO_OUT_A[95:64], 32'h0);
    ahb_read(1'b0, 32'h20, 32'h1A0, "rd_p1_out");
    ahb_read(1'b0, 32'h24, 32'hFF, "rd_p1_oe");
    ahb_read(1'b0, 32'h2C, 32'h0, "rd_p1_set");
    ahb_read(1'b0, 32'h30, 32'h0, "rd_p1_clr");

    // Pin update lands one cycle after the data phase
    ahb_write(1'b0, 32'h20, 32'h5A5A);
    check("p1_pin_before_commit", GPIO_OUT_A[63:32], 32'h1A0);
    tick();
    check("p1_pin_after_commit", GPIO_OUT_A[63:32], 32'h5A5A);

    // Port index beyond NUM_PORTS
    ahb_write(1'b0, 32'h60, 32'hFFFF_FFFF);
    ahb_write(1'b0, 32'hE4, 32'hFFFF_FFFF);
    tick();
    check("oor_pin_out", GPIO_OUT_A, {32'h0, 32'h5A5A, 32'h0});
    check("oor_pin_oe", GPIO_OE_A, {32'h0, 32'hFF, 32'h0});
    ahb_read(1'b0, 32'h60, 32'h0, "rd_p3_out");
    ahb_read(1'b0, 32'hE4, 32'h0, "rd_p7_oe");

    // Input synchroniser latency on port 2
    tick();
    gin_a[95:64] = 32'h3C;
    addr_phase(1'b0, 32'h48, 1'b0);
    exp_q.push_back(32'h0);
    name_q.push_back("rd_p2_in_1cyc");
    tick();
    addr_phase(1'b0, 32'h48, 1'b0);
    exp_q.push_back(32'h3C);
    name_q.push_back("rd_p2_in_2cyc");
    tick();
    bus_idle();
    ahb_read(1'b0, 32'h5C, 32'h3C, "rd_p2_status_no_en");
    check("irq_masked", IRQ_A, 3'h0);

    // Back-to-back write then read
    ahb_wr_rd(32'h44, 32'h1234_5678, "b2b_p2_oe");
    ahb_wr_rd(32'h54, 32'h0000_0004, "b2b_p2_irq_en");
    tick();
    check("p2_irq", IRQ_A[2], 1'b1);
    check("p2_pin_oe", GPIO_OE_A[95:64], 32'h1234_5678);

    // Port 0 edge interrupts
    ahb_write(1'b0, 32'h14, 32'h1);
    ahb_write(1'b0, 32'h18, 32'h0);
    tick();
    gin_a[1:0] = 2'b11;
    repeat (3) tick();
    check("p0_irq_latency_lo", IRQ_A[0], 1'b0);
    tick();
    check("p0_irq_latency_hi", IRQ_A[0], 1'b1);
    ahb_read(1'b0, 32'h1C, 32'h3, "rd_p0_status_rise");
    ahb_write(1'b0, 32'h1C, 32'h1);
    tick();
    check("p0_irq_clear_lag", IRQ_A[0], 1'b1);
    tick();
    check("p0_irq_cleared", IRQ_A[0], 1'b0);
    ahb_read(1'b0, 32'h1C, 32'h2, "rd_p0_status_w1c");
    ahb_write(1'b0, 32'h1C, 32'h2);
    ahb_read(1'b0, 32'h1C, 32'h0, "rd_p0_status_clr");
    gin_a[1:0] = 2'b00;
    repeat (4) tick();
    ahb_read(1'b0, 32'h1C, 32'h0, "rd_p0_status_fall_ignored");
    check("p0_irq_fall_ignored", IRQ_A[0], 1'b0);

    // Falling-edge mode; changing EDGE alone must not set STATUS
    ahb_write(1'b0, 32'h18, 32'h1);
    ahb_read(1'b0, 32'h1C, 32'h0, "rd_p0_status_edge_chg");
    gin_a[0] = 1'b1;
    repeat (4) tick();
    ahb_read(1'b0, 32'h1C, 32'h0, "rd_p0_status_rise_ignored");
    gin_a[0] = 1'b0;
    repeat (4) tick();
    ahb_read(1'b0, 32'h1C, 32'h1, "rd_p0_status_fall");
    check("p0_irq_fall", IRQ_A[0], 1'b1);
    ahb_write(1'b0, 32'h1C, 32'h1);

    // W1C colliding with a new edge on bit 3
    tick();
    gin_a[3] = 1'b1;
    tick();
    addr_phase(1'b0, 32'h1C, 1'b1);
    tick();
    bus_idle();
    HWDATA = 32'h8;
    ahb_read(1'b0, 32'h1C, 32'h8, "rd_p0_status_collision");

    // 2-port, 8-bit build
    ahb_write(1'b1, 32'h00, 32'hFFFF_FFFF);
    ahb_read(1'b1, 32'h00, 32'hFF, "b_rd_p0_out");
    ahb_write(1'b1, 32'h20, 32'h12);
    tick();
    check("b_pin_out", GPIO_OUT_B, 16'h12FF);
    ahb_write(1'b1, 32'h60, 32'hFFFF_FFFF);
    ahb_write(1'b1, 32'h64, 32'hFFFF_FFFF);
    tick();
    check("b_oor_pin_out", GPIO_OUT_B, 16'h12FF);
    check("b_oor_pin_oe", GPIO_OE_B, 16'h0);
    ahb_read(1'b1, 32'h60, 32'h0, "b_rd_p3_out");
    check("b_hresp", HRESP_B, 1'b0);

    // Reset during a write data phase
    tick();
    addr_phase(1'b0, 32'h00, 1'b1);
    tick();
    bus_idle();
    HWDATA = 32'hAA;
    #2;
    HRESETn = 1'b0;
    #1;
    check("midrst_gpio_out", GPIO_OUT_A, 96'h0);
    check("midrst_gpio_oe", GPIO_OE_A, 96'h0);
    check("midrst_irq", IRQ_A, 3'h0);
    check("midrst_b_out", GPIO_OUT_B, 16'h0);
    repeat (2) tick();
    HRESETn = 1'b1;
    tick();
    check("postrst_gpio_out", GPIO_OUT_A, 96'h0);
    ahb_read(1'b0, 32'h00, 32'h0, "rd_p0_out_postrst");

    repeat (3) tick();
    check("scoreboard_drained", 128'(exp_q.size()), 128'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
